fpga_cfg_loader: RTL

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

---
 rtl/fpga_cfg_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: accepts configuration words and fans each word out across
// NUM_CHAINS CRAM shift chains, in write or verify (readback compare) mode.
module fpga_cfg_loader #(
  parameter int WORD_W     = 16,
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_mode,
  input  logic                  cfg_abort,
  input  logic [WORD_W-1:0]     cfg_word,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  chain_shift_en,
  output logic [NUM_CHAINS-1:0] chain_data_out,
  input  logic [NUM_CHAINS-1:0] chain_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  mismatch,
  output logic                  aborted
);

  localparam int STEPS       = WORD_W / NUM_CHAINS;
  localparam int TOTAL_WORDS = CHAIN_LEN * NUM_CHAINS / WORD_W;

  if ((WORD_W % NUM_CHAINS) != 0 || ((CHAIN_LEN * NUM_CHAINS) % WORD_W) != 0) begin : g_param_check
    $error("fpga_cfg_loader: WORD_W/NUM_CHAINS and CHAIN_LEN*NUM_CHAINS/WORD_W must divide exactly");
  end

  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int AW = $clog2(TOTAL_WORDS + 1);
  localparam int WW = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);
  localparam logic [AW-1:0] WORDS_ALL = AW'(TOTAL_WORDS);
  localparam logic [WW-1:0] LAST_WORD = WW'(TOTAL_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  mode_q;
  logic                  buf_full_q;
  logic                  mismatch_q;
  logic                  aborted_q;
  logic [WORD_W-1:0]     data_q;
  logic [SW-1:0]         step_q;
  logic [AW-1:0]         accepted_q;
  logic [WW-1:0]         word_q;
  logic                  xfer;
  logic                  step_wrap;
  logic                  last_shift;
  logic                  start_op;
  logic                  abort_op;
  logic [NUM_CHAINS-1:0] cur_bits;

  // The buffer shifts right by NUM_CHAINS per step, so the low slice always
  // holds bits step*NUM_CHAINS+c without a variable-offset mux.
  assign cur_bits = data_q[NUM_CHAINS-1:0];

  always_comb begin
    chain_shift_en = (state_q == RUN) && buf_full_q;
    step_wrap      = chain_shift_en && (step_q == LAST_STEP);
    last_shift     = step_wrap && (word_q == LAST_WORD);
    cfg_ready      = (state_q == RUN) && (accepted_q < WORDS_ALL) &&
                     (!buf_full_q || (step_q == LAST_STEP)) && !cfg_abort;
    xfer           = cfg_valid && cfg_ready;
    start_op       = (state_q == IDLE) && cfg_start;
    abort_op       = (state_q == RUN) && cfg_abort;
    busy           = (state_q == RUN);
    done           = (state_q == DONE);
    mismatch       = mismatch_q;
    aborted        = aborted_q;
    chain_data_out = '0;
    if (chain_shift_en) begin
      chain_data_out = mode_q ? chain_data_in : cur_bits;
    end
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_op) state_d = RUN;
      RUN: begin
        if (abort_op)        state_d = IDLE;
        else if (last_shift) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      buf_full_q <= 1'b0;
      mismatch_q <= 1'b0;
      aborted_q  <= 1'b0;
      data_q     <= '0;
      step_q     <= '0;
      accepted_q <= '0;
      word_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_op) begin
        mode_q     <= cfg_mode;
        buf_full_q <= 1'b0;
        mismatch_q <= 1'b0;
        aborted_q  <= 1'b0;
        step_q     <= '0;
        accepted_q <= '0;
        word_q     <= '0;
      end else begin
        if (abort_op) aborted_q <= 1'b1;
        if (chain_shift_en) begin
          step_q <= step_wrap ? '0 : step_q + SW'(1);
          data_q <= data_q >> NUM_CHAINS;
          if (step_wrap) word_q <= word_q + WW'(1);
          if (mode_q && (chain_data_in != cur_bits)) mismatch_q <= 1'b1;
        end
        if (xfer) begin
          data_q     <= cfg_word;
          buf_full_q <= 1'b1;
          accepted_q <= accepted_q + AW'(1);
        end else if (step_wrap) begin
          buf_full_q <= 1'b0;
        end
      end
    end
  end

endmodule
